// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-memory port arbiter and its surroundings:
// CPU load/store port, debug access path and the single memory port.
interface dmem_port_arbiter_if #(
    parameter int DEPTH = 1024
) ();
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic                 cpu_enable;
    logic                 cpu_mem_read;
    logic                 cpu_mem_write;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [31:0]          cpu_rdata;
    logic                 cpu_stall;

    logic                 dbg_req;
    logic                 dbg_rw;
    logic [8:0]           dbg_addr;
    logic [31:0]          dbg_wdata;
    logic                 dbg_busy;
    logic                 dbg_resp_valid;
    logic [41:0]          dbg_resp_data;

    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_we;
    logic                 mem_re;
    logic [31:0]          mem_rdata;
    logic                 init_done;

    // Requesters and the memory itself
    modport master (
        output cpu_enable, cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_rw, dbg_addr, dbg_wdata,
        input  dbg_busy, dbg_resp_valid, dbg_resp_data,
        input  mem_addr, mem_wdata, mem_we, mem_re, init_done,
        output mem_rdata
    );

    // The arbiter
    modport slave (
        input  cpu_enable, cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_rw, dbg_addr, dbg_wdata,
        output dbg_busy, dbg_resp_valid, dbg_resp_data,
        output mem_addr, mem_wdata, mem_we, mem_re, init_done,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and the debug
// path; zero-fills memory after reset, then favours the CPU with bounded starvation.
module dmem_port_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int WAIT_BITS = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_BITS-1:0] WAIT_MAX  = WAIT_BITS'(STARVE_LIMIT);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e               state_q;
    logic [ADDR_BITS-1:0] clr_ptr_q;
    logic [ADDR_BITS-1:0] clr_ptr_d;
    logic                 pend_q;
    logic                 pend_rw_q;
    logic [8:0]           pend_addr_q;
    logic [31:0]          pend_wdata_q;
    logic [WAIT_BITS-1:0] wait_cnt_q;
    logic [WAIT_BITS-1:0] wait_cnt_d;
    logic                 init_done_q;
    logic                 resp_valid_q;
    logic [41:0]          resp_data_q;

    logic                 running_s;
    logic                 cpu_access_s;
    logic                 dbg_serve_s;
    logic                 accept_s;
    logic [ADDR_BITS-1:0] cpu_idx_s;
    logic [ADDR_BITS-1:0] dbg_idx_s;
    logic                 unused_s;

    // Byte-offset bits and bits above the memory range are intentionally dropped
    assign unused_s = ^{bus.cpu_addr[31:ADDR_BITS+2], bus.cpu_addr[1:0]};

    // Port ownership decision and next-value helpers
    always_comb begin
        running_s    = (state_q == ST_RUN);
        cpu_access_s = bus.cpu_mem_read | bus.cpu_mem_write;
        cpu_idx_s    = bus.cpu_addr[ADDR_BITS+1:2];
        dbg_idx_s    = ADDR_BITS'(pend_addr_q);
        dbg_serve_s  = running_s & pend_q &
                       (~bus.cpu_enable | ~cpu_access_s | (wait_cnt_q == WAIT_MAX));
        accept_s     = running_s & ~pend_q & bus.dbg_req;
        clr_ptr_d    = clr_ptr_q + 1'b1;
        if (wait_cnt_q == WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Memory port mux and CPU-side handshake outputs
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0000_0000;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.cpu_rdata = 32'h0000_0000;
        bus.cpu_stall = 1'b1;
        if (!running_s) begin
            bus.mem_addr  = clr_ptr_q;
            bus.mem_we    = 1'b1;
        end else if (dbg_serve_s) begin
            // A steal cycle stalls only a CPU that actually wanted the port
            bus.mem_addr  = dbg_idx_s;
            bus.mem_wdata = pend_wdata_q;
            bus.mem_we    = pend_rw_q;
            bus.mem_re    = ~pend_rw_q;
            bus.cpu_stall = bus.cpu_enable & cpu_access_s;
        end else begin
            bus.mem_addr  = cpu_idx_s;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = bus.cpu_mem_write;
            bus.mem_re    = bus.cpu_mem_read & ~bus.cpu_mem_write;
            bus.cpu_rdata = (bus.cpu_mem_read & ~bus.cpu_mem_write) ? bus.mem_rdata : 32'h0000_0000;
            bus.cpu_stall = 1'b0;
        end
        bus.dbg_busy = ~running_s | pend_q;
    end

    assign bus.init_done      = init_done_q;
    assign bus.dbg_resp_valid = resp_valid_q;
    assign bus.dbg_resp_data  = resp_data_q;

    // Sequencer: zero-fill, debug slot, starvation counter and response register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            pend_q       <= 1'b0;
            pend_rw_q    <= 1'b0;
            pend_addr_q  <= 9'd0;
            pend_wdata_q <= 32'h0000_0000;
            wait_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 42'd0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_d;
                    if (clr_ptr_q == LAST_ADDR) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    resp_valid_q <= dbg_serve_s;
                    if (dbg_serve_s) begin
                        resp_data_q <= {pend_rw_q, pend_addr_q,
                                        pend_rw_q ? pend_wdata_q : bus.mem_rdata};
                        pend_q      <= 1'b0;
                    end else if (pend_q) begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                    if (accept_s) begin
                        pend_q       <= 1'b1;
                        pend_rw_q    <= bus.dbg_rw;
                        pend_addr_q  <= bus.dbg_addr;
                        pend_wdata_q <= bus.dbg_wdata;
                        wait_cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end
endmodule
